// File: rtl/stage2_classifier.sv
// Output layer of the digit classifier: 20 hidden activations x 10 nodes MAC, bias, argmax.
// Build option SCORE_SAT_EN: saturate scores to 16 bits instead of wrapping.
module stage2_classifier #(
  parameter int unsigned N_IN  = 20,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned DW    = 16,
  parameter int unsigned FRAC  = 10,
  parameter int unsigned ACC_W = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stage1_done,
  input  logic signed [DW-1:0] stage2_in [0:N_IN-1],
  input  logic signed [DW-1:0] w23_wrdata,
  input  logic [7:0]           wr_w23addr,
  input  logic                 we_w23,
  input  logic signed [DW-1:0] b23_wrdata,
  input  logic [3:0]           wr_b23addr,
  input  logic                 we_b23,
  output logic signed [DW-1:0] scores [0:N_OUT-1],
  output logic [3:0]           digit,
  output logic                 busy,
  output logic                 stage2_done
);

  localparam int unsigned WDEPTH = N_IN * N_OUT;
  localparam logic [7:0]  WADDR_LIM = 8'(WDEPTH);
  localparam logic [3:0]  BADDR_LIM = 4'(N_OUT);
  localparam logic [4:0]  J_LAST    = 5'(N_IN);
  localparam logic [3:0]  N_LAST    = 4'(N_OUT - 1);

  typedef enum logic [2:0] {StIdle, StMac, StBias, StArgmax, StDone} state_e;

  state_e state_q, state_d;

  logic                 s1_done_q;
  logic                 start;
  logic signed [DW-1:0] x_q [0:N_IN-1];
  logic signed [DW-1:0] x_d [0:N_IN-1];
  logic signed [DW-1:0] xcur_q, xcur_d;
  logic                 pv_q, pv_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]           n_q, n_d;
  logic [4:0]           j_q, j_d;
  logic signed [DW-1:0] best_q, best_d;
  logic [3:0]           best_idx_q, best_idx_d;
  logic signed [DW-1:0] scores_q [0:N_OUT-1];
  logic signed [DW-1:0] scores_d [0:N_OUT-1];
  logic [3:0]           digit_q, digit_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Coefficient memories
  logic signed [DW-1:0] w_mem [0:WDEPTH-1];
  logic signed [DW-1:0] b_mem [0:N_OUT-1];
  logic signed [DW-1:0] w_rdata, b_rdata;
  logic [7:0]           w_raddr;
  logic                 w_re;

  assign w_raddr = 8'((32'(n_q) * N_IN) + 32'(j_q));
  assign w_re    = (state_q == StMac) && (j_q < J_LAST);

  // Non-blocking write/read gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (we_w23 && !busy_q && (wr_w23addr < WADDR_LIM)) begin
      w_mem[wr_w23addr] <= w23_wrdata;
    end
    if (we_b23 && !busy_q && (wr_b23addr < BADDR_LIM)) begin
      b_mem[wr_b23addr] <= b23_wrdata;
    end
    if (w_re) begin
      w_rdata <= w_mem[w_raddr];
    end
    b_rdata <= b_mem[n_q];
  end

  // Datapath
  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_sh;
  logic signed [ACC_W-1:0]  sum;
  logic signed [DW-1:0]     score_res;

  assign prod     = 32'(xcur_q) * 32'(w_rdata);
  assign prod_ext = ACC_W'(prod);
  assign bias_sh  = ACC_W'(b_rdata) <<< FRAC;
  assign sum      = acc_q + bias_sh;

`ifdef SCORE_SAT_EN
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = -S_MAX - ACC_W'(1);
  logic signed [ACC_W-1:0] shifted;
  logic                    unused_sum;

  assign shifted    = sum >>> FRAC;
  assign unused_sum = ^sum[FRAC-1:0];

  always_comb begin
    if (shifted > S_MAX) begin
      score_res = S_MAX[DW-1:0];
    end else if (shifted < S_MIN) begin
      score_res = S_MIN[DW-1:0];
    end else begin
      score_res = shifted[DW-1:0];
    end
  end
`else
  logic unused_sum;

  assign score_res  = sum[FRAC+DW-1:FRAC];
  assign unused_sum = ^{sum[FRAC-1:0], sum[ACC_W-1:FRAC+DW]};
`endif

  assign start = stage1_done & ~s1_done_q;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    xcur_d     = xcur_q;
    pv_d       = 1'b0;
    acc_d      = acc_q;
    n_d        = n_q;
    j_d        = j_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    scores_d   = scores_q;
    digit_d    = digit_q;
    busy_d     = busy_q;
    done_d     = done_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = stage2_in;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          n_d     = 4'd0;
          j_d     = 5'd0;
          acc_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        // Product of the address issued last cycle meets its weight now.
        if (pv_q) begin
          acc_d = acc_q + prod_ext;
        end
        if (j_q < J_LAST) begin
          xcur_d = x_q[j_q];
          pv_d   = 1'b1;
          j_d    = j_q + 5'd1;
        end else begin
          state_d = StBias;
        end
      end
      StBias: begin
        scores_d[n_q] = score_res;
        j_d           = 5'd0;
        acc_d         = '0;
        if (n_q == N_LAST) begin
          state_d = StArgmax;
        end else begin
          n_d     = n_q + 4'd1;
          state_d = StMac;
        end
      end
      StArgmax: begin
        if (j_q == 5'd0) begin
          best_d     = scores_q[0];
          best_idx_d = 4'd0;
        end else if (scores_q[j_q[3:0]] > best_q) begin
          best_d     = scores_q[j_q[3:0]];
          best_idx_d = j_q[3:0];
        end
        j_d = j_q + 5'd1;
        if (j_q[3:0] == N_LAST) begin
          digit_d = best_idx_d;
          state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      s1_done_q  <= 1'b0;
      x_q        <= '{default: '0};
      xcur_q     <= '0;
      pv_q       <= 1'b0;
      acc_q      <= '0;
      n_q        <= 4'd0;
      j_q        <= 5'd0;
      best_q     <= '0;
      best_idx_q <= 4'd0;
      scores_q   <= '{default: '0};
      digit_q    <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_done_q  <= stage1_done;
      x_q        <= x_d;
      xcur_q     <= xcur_d;
      pv_q       <= pv_d;
      acc_q      <= acc_d;
      n_q        <= n_d;
      j_q        <= j_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      scores_q   <= scores_d;
      digit_q    <= digit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign scores      = scores_q;
  assign digit       = digit_q;
  assign busy        = busy_q;
  assign stage2_done = done_q;

endmodule

// File: tb/tb_stage2_classifier.sv
// Directed self-checking bench for stage2_classifier (honours SCORE_SAT_EN when defined).
module tb_stage2_classifier;

  logic               clk = 1'b0;
  logic               reset;
  logic               stage1_done;
  logic signed [15:0] stage2_in [0:19];
  logic signed [15:0] w23_wrdata;
  logic [7:0]         wr_w23addr;
  logic               we_w23;
  logic signed [15:0] b23_wrdata;
  logic [3:0]         wr_b23addr;
  logic               we_b23;
  logic signed [15:0] scores [0:9];
  logic [3:0]         digit;
  logic               busy;
  logic               stage2_done;

  int n_cmp = 0;
  int n_err = 0;

  stage2_classifier dut (
    .clk         (clk),
    .reset       (reset),
    .stage1_done (stage1_done),
    .stage2_in   (stage2_in),
    .w23_wrdata  (w23_wrdata),
    .wr_w23addr  (wr_w23addr),
    .we_w23      (we_w23),
    .b23_wrdata  (b23_wrdata),
    .wr_b23addr  (wr_b23addr),
    .we_b23      (we_b23),
    .scores      (scores),
    .digit       (digit),
    .busy        (busy),
    .stage2_done (stage2_done)
  );

  always #5 clk = ~clk;

  task automatic set_x(input logic [15:0] v);
    for (int j = 0; j < 20; j++) stage2_in[j] = v;
  endtask

  task automatic fill_w(input logic [15:0] v);
    for (int a = 0; a < 200; a++) begin
      @(negedge clk);
      we_w23 = 1'b1; wr_w23addr = 8'(a); w23_wrdata = v;
    end
    @(negedge clk);
    we_w23 = 1'b0;
  endtask

  task automatic wr_w(input int a, input logic [15:0] v);
    @(negedge clk);
    we_w23 = 1'b1; wr_w23addr = 8'(a); w23_wrdata = v;
    @(negedge clk);
    we_w23 = 1'b0;
  endtask

  task automatic wr_b(input int a, input logic [15:0] v);
    @(negedge clk);
    we_b23 = 1'b1; wr_b23addr = 4'(a); b23_wrdata = v;
    @(negedge clk);
    we_b23 = 1'b0;
  endtask

  // Start a run and count edges (including the start edge) until stage2_done is seen.
  task automatic run_wait(input bit hold, output int cycles);
    @(negedge clk);
    stage1_done = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      if (!hold && cycles == 3) stage1_done = 1'b0;
    end while (!stage2_done && cycles < 400);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 10; n++) begin
      n_cmp++;
      if (scores[n] !== 16'h0000) begin
        n_err++; $display("FAIL reset score[%0d]: got %h expected 0000", n, scores[n]);
      end
    end
    n_cmp++;
    if (digit !== 4'd0) begin n_err++; $display("FAIL reset digit: got %0d expected 0", digit); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_cmp++;
    if (stage2_done !== 1'b0) begin
      n_err++; $display("FAIL reset done: got %b expected 0", stage2_done);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_uniform;
    set_x(16'h0400);
    fill_w(16'h0000);
    for (int j = 0; j < 20; j++) wr_w(60 + j, 16'h0400);
    for (int n = 0; n < 10; n++) wr_b(n, 16'h0000);
  endtask

  task automatic test_uniform;
    int cyc;
    logic [15:0] e;
    load_uniform();
    run_wait(1'b0, cyc);
    n_cmp++;
    if (cyc !== 232) begin n_err++; $display("FAIL uniform latency: got %0d expected 232", cyc); end
    for (int n = 0; n < 10; n++) begin
      e = (n == 3) ? 16'h5000 : 16'h0000;
      n_cmp++;
      if (scores[n] !== e) begin
        n_err++; $display("FAIL uniform score[%0d]: got %h expected %h", n, scores[n], e);
      end
    end
    n_cmp++;
    if (digit !== 4'd3) begin n_err++; $display("FAIL uniform digit: got %0d expected 3", digit); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL uniform busy: got %b expected 0", busy); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (stage2_done !== 1'b1) begin
      n_err++; $display("FAIL uniform done hold: got %b expected 1", stage2_done);
    end
  endtask

  task automatic test_negative_bias;
    int cyc;
    logic [15:0] e;
    set_x(16'hFC00);
    fill_w(16'h0200);
    for (int n = 0; n < 10; n++) wr_b(n, 16'(n * 64));
    run_wait(1'b0, cyc);
    n_cmp++;
    if (cyc !== 232) begin n_err++; $display("FAIL negbias latency: got %0d expected 232", cyc); end
    for (int n = 0; n < 10; n++) begin
      e = 16'hD800 + 16'(n * 64);
      n_cmp++;
      if (scores[n] !== e) begin
        n_err++; $display("FAIL negbias score[%0d]: got %h expected %h", n, scores[n], e);
      end
    end
    n_cmp++;
    if (digit !== 4'd9) begin n_err++; $display("FAIL negbias digit: got %0d expected 9", digit); end
  endtask

  task automatic test_tie;
    int cyc;
    logic [15:0] e;
    set_x(16'h0400);
    fill_w(16'h0000);
    wr_w(40, 16'h1000);
    wr_w(140, 16'h1000);
    wr_w(100, 16'h0800);
    wr_w(180, 16'hF000);
    for (int n = 0; n < 10; n++) wr_b(n, 16'h0000);
    run_wait(1'b0, cyc);
    for (int n = 0; n < 10; n++) begin
      e = (n == 2 || n == 7) ? 16'h1000 : (n == 5) ? 16'h0800 : (n == 9) ? 16'hF000 : 16'h0000;
      n_cmp++;
      if (scores[n] !== e) begin
        n_err++; $display("FAIL tie score[%0d]: got %h expected %h", n, scores[n], e);
      end
    end
    n_cmp++;
    if (digit !== 4'd2) begin n_err++; $display("FAIL tie digit: got %0d expected 2", digit); end
  endtask

  task automatic test_overflow;
    int cyc;
    logic [15:0] e0;
`ifdef SCORE_SAT_EN
    e0 = 16'h7FFF;
`else
    e0 = 16'h5000;
`endif
    set_x(16'h7C00);
    fill_w(16'h0000);
    for (int j = 0; j < 20; j++) wr_w(j, 16'h7C00);
    for (int n = 0; n < 10; n++) wr_b(n, 16'h0000);
    run_wait(1'b0, cyc);
    n_cmp++;
    if (cyc !== 232) begin n_err++; $display("FAIL overflow latency: got %0d expected 232", cyc); end
    n_cmp++;
    if (scores[0] !== e0) begin
      n_err++; $display("FAIL overflow score[0]: got %h expected %h", scores[0], e0);
    end
    n_cmp++;
    if (scores[1] !== 16'h0000) begin
      n_err++; $display("FAIL overflow score[1]: got %h expected 0000", scores[1]);
    end
    n_cmp++;
    if (digit !== 4'd0) begin n_err++; $display("FAIL overflow digit: got %0d expected 0", digit); end
  endtask

  task automatic test_reset_restart;
    int cyc;
    logic [15:0] e;
    load_uniform();
    @(negedge clk);
    stage1_done = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 3) stage1_done = 1'b0;
    end
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL midrun busy: got %b expected 1", busy); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 10; n++) begin
      n_cmp++;
      if (scores[n] !== 16'h0000) begin
        n_err++; $display("FAIL midreset score[%0d]: got %h expected 0000", n, scores[n]);
      end
    end
    n_cmp++;
    if ({busy, stage2_done, digit} !== 6'd0) begin
      n_err++; $display("FAIL midreset busy/done/digit: got %b expected 000000",
                        {busy, stage2_done, digit});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL postreset idle busy: got %b expected 0", busy); end
    run_wait(1'b0, cyc);
    n_cmp++;
    if (cyc !== 232) begin n_err++; $display("FAIL restart latency: got %0d expected 232", cyc); end
    for (int n = 0; n < 10; n++) begin
      e = (n == 3) ? 16'h5000 : 16'h0000;
      n_cmp++;
      if (scores[n] !== e) begin
        n_err++; $display("FAIL restart score[%0d]: got %h expected %h", n, scores[n], e);
      end
    end
    n_cmp++;
    if (digit !== 4'd3) begin n_err++; $display("FAIL restart digit: got %0d expected 3", digit); end
  endtask

  task automatic test_handshake;
    int first_done, busy_rises, cyc;
    logic prev_busy;
    logic [15:0] e;
    first_done = 0; busy_rises = 0; prev_busy = busy;
    @(negedge clk);
    stage1_done = 1'b1;
    for (int c = 1; c <= 500; c++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) busy_rises++;
      prev_busy = busy;
      if (stage2_done && first_done == 0) first_done = c;
      if (c == 30) begin we_w23 = 1'b1; wr_w23addr = 8'd65; w23_wrdata = 16'h7000; end
      if (c == 31) we_w23 = 1'b0;
      if (c == 50) stage1_done = 1'b0;
      if (c == 52) stage1_done = 1'b1;
    end
    n_cmp++;
    if (busy_rises !== 1) begin n_err++; $display("FAIL handshake runs: got %0d expected 1", busy_rises); end
    n_cmp++;
    if (first_done !== 232) begin
      n_err++; $display("FAIL handshake latency: got %0d expected 232", first_done);
    end
    n_cmp++;
    if (stage2_done !== 1'b1) begin
      n_err++; $display("FAIL handshake done hold: got %b expected 1", stage2_done);
    end
    n_cmp++;
    if (scores[3] !== 16'h5000) begin
      n_err++; $display("FAIL handshake score[3]: got %h expected 5000", scores[3]);
    end
    stage1_done = 1'b0;
    @(posedge clk);
    run_wait(1'b0, cyc);
    for (int n = 0; n < 10; n++) begin
      e = (n == 3) ? 16'h5000 : 16'h0000;
      n_cmp++;
      if (scores[n] !== e) begin
        n_err++; $display("FAIL busywrite score[%0d]: got %h expected %h", n, scores[n], e);
      end
    end
    n_cmp++;
    if (digit !== 4'd3) begin n_err++; $display("FAIL busywrite digit: got %0d expected 3", digit); end
  endtask

  initial begin
    reset = 1'b1; stage1_done = 1'b0;
    we_w23 = 1'b0; wr_w23addr = '0; w23_wrdata = '0;
    we_b23 = 1'b0; wr_b23addr = '0; b23_wrdata = '0;
    set_x(16'h0000);
    test_reset();
    test_uniform();
    test_negative_bias();
    test_tie();
    test_overflow();
    test_reset_restart();
    test_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
